// File: rtl/bcd_subtractor_serial.sv
// ---------------------------------------------------------------------------
// bcd_subtractor_serial
//
// Digit-serial BCD subtractor producing |a - b| and a sign flag.
// One BCD digit is processed per clock, least significant digit first,
// with a ripple borrow carried between digits. If the raw difference ends
// with a borrow out (a < b), a second serial pass computes 0 - working
// (ten's complement) to turn the raw result into its magnitude.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   a      in   minuend, packed BCD, digit 0 at [3:0]
//   b      in   subtrahend, packed BCD
//   diff   out  packed BCD magnitude |a - b|, held until next completion
//   neg    out  1 when a < b (never set for a zero result)
//   err    out  1 when the last request contained a digit > 9
//   busy   out  high while an operation is in progress
//   done   out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module bcd_subtractor_serial #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  neg,
    output logic                  err,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        NEG
    } state_t;

    state_t          state_q, state_d;
    // The working register is loaded with a and overwritten in place, one
    // result digit per clock; a separate copy of a is therefore not kept.
    logic [W-1:0]    work_q,   work_d;
    logic [W-1:0]    b_q,      b_d;
    logic            borrow_q, borrow_d;
    logic [IW-1:0]   idx_q,    idx_d;
    logic [W-1:0]    diff_q,   diff_d;
    logic            neg_q,    neg_d;
    logic            err_q,    err_d;
    logic            done_q,   done_d;

    logic [3:0]      cur_work;
    logic [3:0]      cur_b;
    logic [3:0]      op_x;
    logic [3:0]      op_y;
    logic [4:0]      t;
    logic            bout;
    logic [3:0]      res_digit;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Select the digit at the current index from the working and b registers.
    always_comb begin
        cur_work = '0;
        cur_b    = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_work = work_q[4*i +: 4];
                cur_b    = b_q[4*i +: 4];
            end
        end
    end

    // Single digit subtractor shared by both passes: the negate pass is
    // simply 0 - working digit with the same borrow rule.
    always_comb begin
        op_x = (state_q == NEG) ? 4'd0 : cur_work;
        op_y = (state_q == NEG) ? cur_work : cur_b;
        t    = {1'b0, op_x} - {1'b0, op_y} - {4'b0, borrow_q};
        // A negative 5-bit result has its sign bit set; adding ten to the
        // low nibble (mod 16) yields the correct BCD digit in that case.
        bout      = t[4];
        res_digit = bout ? (t[3:0] + 4'd10) : t[3:0];
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        idx_d    = idx_q;
        diff_d   = diff_q;
        neg_d    = neg_q;
        err_d    = err_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (has_bad_digit(a) || has_bad_digit(b)) begin
                        err_d  = 1'b1;
                        diff_d = '0;
                        neg_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        work_d   = a;
                        b_d      = b;
                        borrow_d = 1'b0;
                        idx_d    = '0;
                        err_d    = 1'b0;
                        state_d  = SUB;
                    end
                end
            end

            SUB, NEG: begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) begin
                        work_d[4*i +: 4] = res_digit;
                    end
                end
                borrow_d = bout;
                idx_d    = idx_q + IW'(1);

                if (idx_q == LAST_IDX) begin
                    if (state_q == NEG) begin
                        diff_d  = work_d;
                        neg_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (!bout) begin
                        diff_d  = work_d;
                        neg_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d    = '0;
                        borrow_d = 1'b0;
                        state_d  = NEG;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
            diff_q   <= diff_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign diff = diff_q;
    assign neg  = neg_q;
    assign err  = err_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// ---------------------------------------------------------------------------
// tb_bcd_subtractor_serial
//
// Self-checking bench for bcd_subtractor_serial with DIGITS = 4. Directed
// vectors and random requests are checked against an integer-arithmetic
// reference; hand-written sequences cover start-while-busy, held start and
// reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_bcd_subtractor_serial;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         neg;
    logic         err;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .diff  (diff),
        .neg   (neg),
        .err   (err),
        .busy  (busy),
        .done  (done)
    );

    // lat = posedges after the start edge until done is visible
    // (0 for an invalid request, whose done is raised by the start edge).
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         n;
        logic         e;
        int           lat;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------
    function automatic bit bcd_ok(input logic [W-1:0] v);
        logic [W-1:0] tmp;
        tmp = v;
        for (int i = 0; i < DIGITS; i++) begin
            if ((tmp & 16'hF) > 9) return 1'b0;
            tmp = tmp >> 4;
        end
        return 1'b1;
    endfunction

    function automatic int bcd_val(input logic [W-1:0] v);
        int r;
        int scale;
        logic [W-1:0] tmp;
        r = 0;
        scale = 1;
        tmp = v;
        for (int i = 0; i < DIGITS; i++) begin
            r = r + int'(tmp & 16'hF) * scale;
            scale = scale * 10;
            tmp = tmp >> 4;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r;
        int m;
        r = '0;
        m = n;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | (W'(m % 10) << (4 * i));
            m = m / 10;
        end
        return r;
    endfunction

    task automatic model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                         output logic [W-1:0] d, output logic n, output logic e,
                         output int lat);
        int va;
        int vb;
        if (!bcd_ok(ai) || !bcd_ok(bi)) begin
            d = '0; n = 1'b0; e = 1'b1; lat = 0;
        end else begin
            va = bcd_val(ai);
            vb = bcd_val(bi);
            e = 1'b0;
            if (va >= vb) begin
                d = to_bcd(va - vb); n = 1'b0; lat = DIGITS;
            end else begin
                d = to_bcd(vb - va); n = 1'b1; lat = 2 * DIGITS;
            end
        end
    endtask

    // ---------------- one request, with timing and handshake checks -------
    task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic [W-1:0] ed, input logic en, input logic ee, input int el);
        int cnt;
        bit busy_ok;
        bit seen;
        @(negedge clk);
        a = ai;
        b = bi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cnt = 0;
        busy_ok = 1'b1;
        seen = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            cnt++;
        end
        check($sformatf("%s.done_seen", tag), 32'(seen), 32'd1);
        check($sformatf("%s.latency", tag), 32'(cnt), 32'(el));
        check($sformatf("%s.diff", tag), 32'(diff), 32'(ed));
        check($sformatf("%s.neg", tag), 32'(neg), 32'(en));
        check($sformatf("%s.err", tag), 32'(err), 32'(ee));
        check($sformatf("%s.busy_at_done", tag), 32'(busy), 32'd0);
        if (!ee) check($sformatf("%s.busy_during", tag), 32'(busy_ok), 32'd1);
        @(negedge clk);
        check($sformatf("%s.done_width", tag), 32'(done), 32'd0);
        check($sformatf("%s.diff_held", tag), 32'(diff), 32'(ed));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] md;
        logic         mn;
        logic         me;
        int           ml;
        int           dn_cnt;
        logic [W-1:0] dn_diff;
        logic         dn_neg;
        int           dq[$];

        tbl[0] = '{16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 4};
        tbl[1] = '{16'h1234, 16'h5432, 16'h4198, 1'b1, 1'b0, 8};
        tbl[2] = '{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 4};
        tbl[3] = '{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 8};
        tbl[4] = '{16'h7777, 16'h7777, 16'h0000, 1'b0, 1'b0, 4};
        tbl[5] = '{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 0};
        tbl[6] = '{16'h1234, 16'h1233, 16'h0001, 1'b0, 1'b0, 4};
        tbl[7] = '{16'h0001, 16'hF000, 16'h0000, 1'b0, 1'b1, 0};
        tbl[8] = '{16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 4};
        tbl[9] = '{16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 8};

        // ---- reset state
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        check("reset.diff", 32'(diff), 32'd0);
        check("reset.neg", 32'(neg), 32'd0);
        check("reset.err", 32'(err), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- directed vectors
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].n, tbl[i].e, tbl[i].lat);
        end

        // ---- random requests against the reference model
        for (int i = 0; i < 150; i++) begin
            ra = '0;
            rb = '0;
            for (int j = 0; j < DIGITS; j++) begin
                ra = ra | (W'($urandom_range(0, 9)) << (4 * j));
                rb = rb | (W'($urandom_range(0, 9)) << (4 * j));
            end
            if ($urandom_range(0, 9) == 0) rb = ra;
            if ($urandom_range(0, 9) == 0)
                ra = ra | (W'($urandom_range(10, 15)) << (4 * $urandom_range(0, DIGITS - 1)));
            model(ra, rb, md, mn, me, ml);
            run_op($sformatf("rnd%0d", i), ra, rb, md, mn, me, ml);
        end

        // ---- start while busy is ignored
        @(negedge clk);
        a = 16'h1234;
        b = 16'h5432;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a = 16'h0001;
        b = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        dn_cnt = 0;
        dn_diff = '0;
        dn_neg = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                dn_cnt++;
                dn_diff = diff;
                dn_neg = neg;
            end
            @(negedge clk);
        end
        check("busy_start.done_count", 32'(dn_cnt), 32'd1);
        check("busy_start.diff", 32'(dn_diff), 32'h4198);
        check("busy_start.neg", 32'(dn_neg), 32'd1);
        check("busy_start.idle", 32'(busy), 32'd0);

        // ---- start held high relaunches on the edge right after done
        @(negedge clk);
        a = 16'h0009;
        b = 16'h0003;
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (done) dq.push_back(i);
            @(negedge clk);
        end
        start = 1'b0;
        check("held.done_count", 32'(dq.size()), 32'd2);
        if (dq.size() >= 2) begin
            check("held.first_done", 32'(dq[0]), 32'd4);
            check("held.second_done", 32'(dq[1]), 32'd9);
        end
        check("held.diff", 32'(diff), 32'h0006);
        repeat (12) @(negedge clk);
        check("held.idle", 32'(busy), 32'd0);

        // ---- reset in the middle of a negative operation
        @(negedge clk);
        a = 16'h1234;
        b = 16'h5432;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.diff", 32'(diff), 32'd0);
        check("midrst.neg", 32'(neg), 32'd0);
        check("midrst.err", 32'(err), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        dn_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done) dn_cnt++;
        end
        check("midrst.no_done", 32'(dn_cnt), 32'd0);
        run_op("after_rst", 16'h0050, 16'h0075, 16'h0025, 1'b1, 1'b0, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
